// File: rtl/peak_bin_pkg.sv
// Shared types and default widths for the peak-bin finder and the colour-mapping stage.
package peak_bin_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int SAMPLES_DEF = 32;
   localparam int IDX_W       = $clog2(SAMPLES_DEF);
   localparam int MAG_W_DEF   = 16;
   localparam int MIN_MAG_DEF = 16;

endpackage

// File: rtl/peak_bin_finder_tracker.sv
// Running maximum over one scan: the first word loads unconditionally, later words only if strictly larger.
module peak_tracker #(
   parameter int MAG_W = 16,
   parameter int IW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vld_p1,
   input  logic             first_p1,
   input  logic [MAG_W-1:0] data_p1,
   input  logic [IW-1:0]    idx_p1,
   output logic [MAG_W-1:0] max_nxt,
   output logic [IW-1:0]    idx_nxt
);

   logic [MAG_W-1:0] max_q;
   logic [IW-1:0]    idx_q;
   logic             take;

   // Strict compare keeps the lowest index on ties.
   assign take    = vld_p1 && (first_p1 || (data_p1 > max_q));
   assign max_nxt = take ? data_p1 : max_q;
   assign idx_nxt = take ? idx_p1  : idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= '0;
         idx_q <= '0;
      end else begin
         max_q <= max_nxt;
         idx_q <= idx_nxt;
      end
   end

endmodule

// File: rtl/peak_bin_finder.sv
// Scans one bank of the FFT magnitude RAM and reports the strongest bin, its bank and a strength qualifier.
module peak_bin_finder
   import peak_bin_pkg::*;
#(
   parameter int SAMPLES   = SAMPLES_DEF,
   parameter int MAG_W     = MAG_W_DEF,
   parameter int START_BIN = 1,
   parameter int MIN_MAG   = MIN_MAG_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       ram_sel,
   output logic                       rd_en,
   output logic                       rd_bank,
   output logic [$clog2(SAMPLES)-1:0] rd_addr,
   input  logic [MAG_W-1:0]           rd_data,
   output logic                       busy,
   output logic [$clog2(SAMPLES)-1:0] index_holder,
   output logic                       whichRAM,
   output logic [MAG_W-1:0]           peak_mag,
   output logic                       done,
   output logic                       scan_done
);

   localparam int AW = $clog2(SAMPLES);
   localparam logic [AW-1:0]    FIRST_ADDR = AW'(START_BIN);
   localparam logic [AW-1:0]    LAST_ADDR  = AW'(SAMPLES - 1);
   localparam logic [MAG_W-1:0] MIN_LVL    = MAG_W'(MIN_MAG);

   state_t           state_q, state_d;
   logic             bank_q;
   logic [AW-1:0]    addr_q;
   logic             accept;

   logic             vld_p1;
   logic             first_p1;
   logic [AW-1:0]    addr_p1;

   logic [MAG_W-1:0] max_nxt;
   logic [AW-1:0]    idx_nxt;

   assign accept  = (state_q == IDLE) && start;
   assign rd_bank = bank_q;
   assign rd_addr = addr_q;

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = READ;
         end
         READ: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (addr_q == LAST_ADDR) state_d = DRAIN;
         end
         DRAIN: begin
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bank_q  <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            bank_q <= ram_sel;
            addr_q <= FIRST_ADDR;
         end else if (rd_en && (addr_q != LAST_ADDR)) begin
            addr_q <= addr_q + AW'(1);
         end
      end
   end

   // Stage p1: RAM data returns; align the address and first-word flag with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
         addr_p1  <= '0;
      end else begin
         vld_p1   <= rd_en;
         first_p1 <= rd_en && (addr_q == FIRST_ADDR);
         addr_p1  <= addr_q;
      end
   end

   peak_tracker #(
      .MAG_W (MAG_W),
      .IW    (AW)
   ) u_tracker (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld_p1   (vld_p1),
      .first_p1 (first_p1),
      .data_p1  (rd_data),
      .idx_p1   (addr_p1),
      .max_nxt  (max_nxt),
      .idx_nxt  (idx_nxt)
   );

   // Stage p2: publish the result using the final compare from the DRAIN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_holder <= '0;
         peak_mag     <= '0;
         whichRAM     <= 1'b0;
         done         <= 1'b0;
         scan_done    <= 1'b0;
      end else begin
         scan_done <= (state_q == DRAIN);
         if (state_q == DRAIN) begin
            index_holder <= idx_nxt;
            peak_mag     <= max_nxt;
            whichRAM     <= bank_q;
            done         <= (max_nxt >= MIN_LVL);
         end else if (accept) begin
            done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_peak_bin_finder.sv
// Directed bench for peak_bin_finder with a two-bank RAM model and hand-computed peaks.
module tb_peak_bin_finder;

   localparam int SAMPLES   = 32;
   localparam int MAG_W     = 16;
   localparam int START_BIN = 1;
   localparam int MIN_MAG   = 16;
   localparam int N         = SAMPLES - START_BIN;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             ram_sel;
   logic             rd_en;
   logic             rd_bank;
   logic [4:0]       rd_addr;
   logic [MAG_W-1:0] rd_data;
   logic             busy;
   logic [4:0]       index_holder;
   logic             whichRAM;
   logic [MAG_W-1:0] peak_mag;
   logic             done;
   logic             scan_done;

   logic [MAG_W-1:0] mem0 [SAMPLES];
   logic [MAG_W-1:0] mem1 [SAMPLES];
   int               dc_reads;
   int               n_cmp;
   int               n_err;

   peak_bin_finder #(
      .SAMPLES   (SAMPLES),
      .MAG_W     (MAG_W),
      .START_BIN (START_BIN),
      .MIN_MAG   (MIN_MAG)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .ram_sel      (ram_sel),
      .rd_en        (rd_en),
      .rd_bank      (rd_bank),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .index_holder (index_holder),
      .whichRAM     (whichRAM),
      .peak_mag     (peak_mag),
      .done         (done),
      .scan_done    (scan_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM: data valid one cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
         if (rd_addr == 5'd0) dc_reads <= dc_reads + 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic fill(input bit bank, input logic [MAG_W-1:0] val);
      for (int i = 0; i < SAMPLES; i++) begin
         if (bank) mem1[i] = val;
         else      mem0[i] = val;
      end
   endtask

   // Called #1 after a posedge with the DUT idle; that cycle is cycle 0.
   task automatic run_scan(input string tag, input bit bank, input int exp_idx, input int exp_mag,
                           input bit exp_done, input int dup_cyc, input bit restart);
      int bad;
      logic [4:0]       prev_idx;
      logic [MAG_W-1:0] prev_mag;
      logic             prev_which;
      bad        = 0;
      prev_idx   = index_holder;
      prev_mag   = peak_mag;
      prev_which = whichRAM;
      start      = 1'b1;
      ram_sel    = bank;
      for (int c = 1; c <= N + 2; c++) begin
         @(posedge clk); #1;
         if (c <= N) begin
            if (!rd_en || rd_addr != 5'(c - 1 + START_BIN) || rd_bank !== bank ||
                !busy || done || scan_done) bad++;
         end
         if (c <= N + 1) begin
            if (index_holder !== prev_idx || peak_mag !== prev_mag || whichRAM !== prev_which) bad++;
         end
         if (c == 1) check_val({tag, "_done_cleared"}, done, 0);
         if (c == N + 1) begin
            check_val({tag, "_drain_rd_en"}, rd_en, 0);
            check_val({tag, "_drain_busy"}, busy, 1);
            check_val({tag, "_drain_scan_done"}, scan_done, 0);
         end
         if (c == N + 2) begin
            check_val({tag, "_scan_done"}, scan_done, 1);
            check_val({tag, "_busy_end"}, busy, 0);
            check_val({tag, "_index"}, index_holder, exp_idx);
            check_val({tag, "_peak_mag"}, peak_mag, exp_mag);
            check_val({tag, "_whichRAM"}, whichRAM, bank);
            check_val({tag, "_done"}, done, exp_done);
         end
         start   = (c == dup_cyc);
         ram_sel = (c == dup_cyc) ? ~bank : bank;
      end
      check_val({tag, "_read_seq"}, bad, 0);
      if (restart) begin
         start   = 1'b1;
         ram_sel = bank;
         @(posedge clk); #1;
         start = 1'b0;
         check_val({tag, "_restart_busy"}, busy, 1);
         check_val({tag, "_restart_done_low"}, done, 0);
         check_val({tag, "_restart_addr"}, rd_addr, START_BIN);
         for (int w = 0; w < 100 && !scan_done; w++) begin
            @(posedge clk); #1;
         end
         check_val({tag, "_restart_scan_done"}, scan_done, 1);
         check_val({tag, "_restart_index"}, index_holder, exp_idx);
      end
      @(posedge clk); #1;
      check_val({tag, "_pulse_one_cycle"}, scan_done, 0);
      check_val({tag, "_done_holds"}, done, exp_done);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      dc_reads = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      ram_sel  = 1'b0;
      fill(0, 16'd10);
      mem0[7] = 16'd500;
      fill(1, 16'd0);
      mem1[3] = 16'd700;
      #12;
      check_val("reset_busy", busy, 0);
      check_val("reset_rd_en", rd_en, 0);
      check_val("reset_outputs", {index_holder, whichRAM, peak_mag, done, scan_done}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_scan("t1_single_peak", 0, 7, 500, 1, 0, 0);

      fill(0, 16'd0);
      mem0[5]  = 16'd300;
      mem0[20] = 16'd300;
      run_scan("t2_tie", 0, 5, 300, 1, 0, 0);

      fill(0, 16'd8);
      run_scan("t3_weak", 0, 1, 8, 0, 0, 0);

      fill(1, 16'd1);
      mem1[0]  = 16'd9999;
      mem1[31] = 16'd200;
      run_scan("t4_bank1_last", 1, 31, 200, 1, 0, 0);
      check_val("t4_dc_never_read", dc_reads, 0);

      run_scan("t5_busy_start", 1, 31, 200, 1, 10, 1);

      fill(0, 16'd0);
      mem0[5]  = 16'd300;
      mem0[20] = 16'd300;
      start   = 1'b1;
      ram_sel = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_busy", busy, 0);
      check_val("t6_rst_rd_en", rd_en, 0);
      check_val("t6_rst_addr_bank", {rd_addr, rd_bank}, 0);
      check_val("t6_rst_results", {index_holder, whichRAM, peak_mag, done, scan_done}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_scan("t6_after_reset", 0, 5, 300, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
